keypad_encoder: RTL

- Scans a 4x4 matrix keypad, debounces presses and releases, and encodes the pressed key as a 4-bit code with a data-available flag.
- Its outputs are the KeypadData/dav pair consumed by the control unit and RAM write path of the system.
- Runs on the fast system clock. dav is a held level, not a pulse, so a slow-clocked consumer (1 Hz control unit) can sample it.

---
 rtl/keypad_encoder_if.sv | 20 ++
 rtl/keypad_encoder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder_if.sv
// Keypad-side and consumer-side signals of keypad_encoder, grouped for port connection.
// master = encoder side (drives columns and key data), slave = keypad/consumer side.
interface keypad_encoder_if;
    logic [3:0] Rows;
    logic [3:0] Cols;
    logic       ack;
    logic [3:0] KeypadData;
    logic       dav;
    logic [1:0] ScanStateFlag;

    modport master (
        input  Rows, ack,
        output Cols, KeypadData, dav, ScanStateFlag
    );

    modport slave (
        output Rows, ack,
        input  Cols, KeypadData, dav, ScanStateFlag
    );
endinterface

// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner with press/release debounce and key-code encoding.
// Optional macro KEYPAD_DAV_LATCH_EN: dav stays set until the consumer pulses ack.
module keypad_encoder #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 8
) (
    input logic              clock50MHz,
    input logic              reset,
    keypad_encoder_if.master kif
);

`ifdef KEYPAD_DAV_LATCH_EN
    localparam bit DAV_LATCH = 1'b1;
`else
    localparam bit DAV_LATCH = 1'b0;
`endif

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [1:0]      col_idx, col_n;
    logic [1:0]      row_idx, row_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [3:0]      data_q, data_n;
    logic            dav_q, dav_n;
    logic [3:0]      rows_m, rows_s;
    logic [TW-1:0]   div_cnt;
    logic            tick;
    logic            row_low;
    logic [CW-1:0]   cnt_inc;

    function automatic logic [1:0] first_low(input logic [3:0] r);
        if (!r[0]) return 2'd0;
        if (!r[1]) return 2'd1;
        if (!r[2]) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: return 4'h1;
            4'b00_01: return 4'h2;
            4'b00_10: return 4'h3;
            4'b00_11: return 4'hA;
            4'b01_00: return 4'h4;
            4'b01_01: return 4'h5;
            4'b01_10: return 4'h6;
            4'b01_11: return 4'hB;
            4'b10_00: return 4'h7;
            4'b10_01: return 4'h8;
            4'b10_10: return 4'h9;
            4'b10_11: return 4'hC;
            4'b11_00: return 4'hE;
            4'b11_01: return 4'h0;
            4'b11_10: return 4'hF;
            default:  return 4'hD;
        endcase
    endfunction

    // NOTE: Rows are asynchronous; nothing may look at them before the second flop.
    always_ff @(posedge clock50MHz or negedge reset) begin
        if (!reset) begin
            rows_m <= 4'hF;
            rows_s <= 4'hF;
        end else begin
            rows_m <= kif.Rows;
            rows_s <= rows_m;
        end
    end

    assign tick = (div_cnt == TW'(SCAN_DIV - 1));

    always_ff @(posedge clock50MHz or negedge reset) begin
        if (!reset) div_cnt <= '0;
        else        div_cnt <= tick ? '0 : div_cnt + TW'(1);
    end

    // Only the captured key is watched once a press has been detected.
    assign row_low = ~rows_s[row_idx];
    assign cnt_inc = cnt + CW'(1);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        col_n   = col_idx;
        row_n   = row_idx;
        cnt_n   = cnt;
        data_n  = data_q;
        dav_n   = dav_q;
        if (DAV_LATCH && kif.ack) dav_n = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (rows_s == 4'hF) begin
                        col_n = col_idx + 2'd1;
                    end else begin
                        row_n   = first_low(rows_s);
                        cnt_n   = CW'(1);
                        state_n = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (row_low) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= CW'(DEBOUNCE_CNT)) begin
                            state_n = PRESSED;
                            data_n  = key_code(row_idx, col_idx);
                            dav_n   = 1'b1;
                        end
                    end else begin
                        state_n = SCAN;
                    end
                end
                PRESSED: begin
                    if (!row_low) begin
                        cnt_n   = CW'(1);
                        state_n = RELEASE;
                    end
                end
                RELEASE: begin
                    if (!row_low) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= CW'(DEBOUNCE_CNT)) begin
                            if (!DAV_LATCH) dav_n = 1'b0;
                            col_n   = col_idx + 2'd1;
                            state_n = SCAN;
                        end
                    end else begin
                        state_n = PRESSED;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

    always_ff @(posedge clock50MHz or negedge reset) begin
        if (!reset) begin
            state   <= SCAN;
            col_idx <= 2'd0;
            row_idx <= 2'd0;
            cnt     <= '0;
            data_q  <= 4'h0;
            dav_q   <= 1'b0;
        end else begin
            state   <= state_n;
            col_idx <= col_n;
            row_idx <= row_n;
            cnt     <= cnt_n;
            data_q  <= data_n;
            dav_q   <= dav_n;
        end
    end

    assign kif.Cols          = ~(4'b0001 << col_idx);
    assign kif.KeypadData    = data_q;
    assign kif.dav           = dav_q;
    assign kif.ScanStateFlag = state;

endmodule
